// File: rtl/mem_bus_unit.sv
`default_nettype none
// ============================================================================
// mem_bus_unit : M-stage load/store unit - data memory, device bridge, faults.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (bus wait-cycle timeout).
// Revision: 1.0
// ============================================================================
module mem_bus_unit #(
  parameter int          DM_WORDS      = 3072,
  parameter int          DEV_NUM       = 2,
  parameter logic [31:0] DEV_BASE      = 32'h0000_7F00,
  parameter int          DEV_SPAN_LOG2 = 4,
  parameter int          TIMEOUT       = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               rvalid,
  output logic [31:0]        rdata,
  output logic               err,
  output logic [DEV_NUM-1:0] pr_sel,
  output logic               pr_we,
  output logic [3:0]         pr_be,
  output logic [31:0]        pr_addr,
  output logic [31:0]        pr_wdata,
  input  logic               pr_ack,
  input  logic [31:0]        pr_rdata
);

  localparam logic [31:0] C_DM_BYTES = 32'(4 * DM_WORDS);
  localparam int          C_DM_AW    = $clog2(DM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]        r_dm [DM_WORDS];
  logic [DEV_NUM-1:0] w_dev_hit;
  logic               w_dm_hit, w_misalign, w_fault, w_dev_req, w_dm_we;
  logic               w_tmo, w_bus_err;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep, w_dm_word;
  logic [C_DM_AW-1:0] w_dm_idx;

  logic [DEV_NUM-1:0] r_sel;
  logic               r_we, r_signed;
  logic [1:0]         r_size, r_lane;
  logic [3:0]         r_be;
  logic [31:0]        r_addr, r_wdata, r_rword;

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    f_extend = {{24{sgn & b[7]}}, b};
      2'd1:    f_extend = {{16{sgn & h[15]}}, h};
      default: f_extend = word;
    endcase
  endfunction

  for (genvar k = 0; k < DEV_NUM; k++) begin : g_slot
    localparam logic [31:0] C_SLOT_BASE = DEV_BASE + (32'(k) << DEV_SPAN_LOG2);
    assign w_dev_hit[k] = (addr[31:DEV_SPAN_LOG2] == C_SLOT_BASE[31:DEV_SPAN_LOG2]);
  end

  assign w_dm_hit   = (addr < C_DM_BYTES);
  assign w_misalign = ((req_size == 2'd1) && addr[0]) || ((req_size == 2'd2) && (addr[1:0] != 2'b00));
  assign w_fault    = (req_size == 2'd3) || w_misalign || (!w_dm_hit && (w_dev_hit == '0));
  assign w_dev_req  = (r_state == S_IDLE) && req_valid && !w_fault && !w_dm_hit;
  assign w_dm_idx   = addr[C_DM_AW+1:2];
  assign w_dm_word  = r_dm[w_dm_idx];

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = wdata;
    case (req_size)
      2'd0: begin
        w_be        = 4'b0001 << addr[1:0];
        w_wdata_rep = {4{wdata[7:0]}};
      end
      2'd1: begin
        w_be        = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int C_TW = $clog2(TIMEOUT + 1);
  logic [C_TW-1:0] r_tcnt;
  logic            r_terr;

  // r_terr survives into DONE so the timeout is reported there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else if (r_state == S_BUS) begin
      if (pr_ack) begin
        r_tcnt <= '0;
        r_terr <= 1'b0;
      end else if (w_tmo) begin
        r_tcnt <= '0;
        r_terr <= 1'b1;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end else if (r_state == S_IDLE) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end
  end

  assign w_tmo     = (r_tcnt == C_TW'(TIMEOUT - 1));
  assign w_bus_err = r_terr;
`else
  assign w_tmo     = 1'b0;
  assign w_bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    rvalid      = 1'b0;
    rdata       = '0;
    err         = 1'b0;
    pr_sel      = '0;
    pr_we       = 1'b0;
    pr_be       = '0;
    pr_addr     = '0;
    pr_wdata    = '0;
    w_dm_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_fault) begin
            rvalid = 1'b1;
            err    = 1'b1;
            rdata  = '1;
          end else if (w_dm_hit) begin
            rvalid  = 1'b1;
            w_dm_we = req_we;
            rdata   = req_we ? '0 : f_extend(w_dm_word, req_size, addr[1:0], req_signed);
          end else begin
            stall       = 1'b1;
            w_state_nxt = S_BUS;
          end
        end
      end
      S_BUS: begin
        stall    = 1'b1;
        pr_sel   = r_sel;
        pr_we    = r_we;
        pr_be    = r_be;
        pr_addr  = r_addr;
        pr_wdata = r_wdata;
        if (pr_ack || w_tmo) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        rvalid      = 1'b1;
        w_state_nxt = S_IDLE;
        if (w_bus_err) begin
          err   = 1'b1;
          rdata = '1;
        end else if (!r_we) begin
          rdata = f_extend(r_rword, r_size, r_lane, r_signed);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset must silence the combinational outputs while the core is still presenting a request.
    if (!reset) begin
      stall    = 1'b0;
      rvalid   = 1'b0;
      rdata    = '0;
      err      = 1'b0;
      pr_sel   = '0;
      pr_we    = 1'b0;
      pr_be    = '0;
      pr_addr  = '0;
      pr_wdata = '0;
      w_dm_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= '0;
      r_lane   <= '0;
      r_be     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rword  <= '0;
    end else begin
      if (w_dev_req) begin
        r_sel    <= w_dev_hit;
        r_we     <= req_we;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_lane   <= addr[1:0];
        r_be     <= w_be;
        r_addr   <= {addr[31:2], 2'b00};
        r_wdata  <= w_wdata_rep;
      end
      if ((r_state == S_BUS) && pr_ack) r_rword <= pr_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_dm[i] <= '0;
    end else if (w_dm_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_dm[w_dm_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_unit : directed scoreboard bench for mem_bus_unit.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_unit;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, pr_ack = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] addr = '0, wdata = '0, pr_rdata = '0;
  logic        stall, rvalid, err, pr_we;
  logic [31:0] rdata, pr_addr, pr_wdata;
  logic [1:0]  pr_sel;
  logic [3:0]  pr_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int          n_stall, n_bus;
  logic [1:0]  sel_seen;
  logic        we_seen;
  logic [3:0]  be_seen;
  logic [31:0] addr_seen, wd_seen;

  always #5 clk = ~clk;

  mem_bus_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .err        (err),
    .pr_sel     (pr_sel),
    .pr_we      (pr_we),
    .pr_be      (pr_be),
    .pr_addr    (pr_addr),
    .pr_wdata   (pr_wdata),
    .pr_ack     (pr_ack),
    .pr_rdata   (pr_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] r, input logic e);
    exp_t t;
    t.rdata = r;
    t.err   = e;
    sb.push_back(t);
  endtask

  // Entered at posedge+1; returns at posedge+1 after the response cycle.
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] prd,
                        input int ack_at);
    exp_t e;
    bit   done = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    addr = a; wdata = wd; pr_rdata = prd;
    n_stall = 0; n_bus = 0; sel_seen = '0; we_seen = 1'b0; be_seen = '0; addr_seen = '0; wd_seen = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (pr_sel != '0) begin
        n_bus++;
        sel_seen  = sel_seen | pr_sel;
        we_seen   = pr_we;
        be_seen   = pr_be;
        addr_seen = pr_addr;
        wd_seen   = pr_wdata;
        pr_ack    = (n_bus == ack_at);
      end else begin
        pr_ack = 1'b0;
      end
      if (rvalid) begin
        done = 1'b1;
        e = sb.pop_front();
        chk({tag, " rdata"}, rdata, e.rdata);
        chk({tag, " err"}, 32'(err), 32'(e.err));
      end
    end
    if (!done) begin
      checks++;
      assert (done) else begin
        errors++;
        $error("FAIL %s: rvalid observed 0 expected 1 within 60 cycles", tag);
      end
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    pr_ack    = 1'b0;
  endtask

  initial begin
    bit done;
    int nrv;
    // Reset held with a live device request present: everything must stay quiet.
    req_valid = 1'b1; req_size = 2'd2; addr = 32'h7F00;
    repeat (2) @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst pr_sel", 32'(pr_sel), 32'd0);
    chk("rst pr_we", 32'(pr_we), 32'd0);
    chk("rst pr_be", 32'(pr_be), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;

    // Word store then sub-word loads from DM, zero latency.
    sb_push(32'h0, 1'b0);          access("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, '0, 0);
    chk("sw10 stalls", 32'(n_stall), 32'd0);
    sb_push(32'h0000_0012, 1'b0);  access("lb13", 1'b0, 2'd0, 1'b1, 32'h13, '0, '0, 0);
    chk("lb13 stalls", 32'(n_stall), 32'd0);
    sb_push(32'h0000_1234, 1'b0);  access("lh12", 1'b0, 2'd1, 1'b1, 32'h12, '0, '0, 0);

    // Byte store into lane 1 only.
    sb_push(32'h0, 1'b0);          access("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, '0, 0);
    sb_push(32'h0, 1'b0);          access("sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'hAAAA_AA80, '0, 0);
    sb_push(32'hFFFF_FF80, 1'b0);  access("lb21", 1'b0, 2'd0, 1'b1, 32'h21, '0, '0, 0);
    sb_push(32'h0000_0080, 1'b0);  access("lbu21", 1'b0, 2'd0, 1'b0, 32'h21, '0, '0, 0);
    sb_push(32'h1122_8044, 1'b0);  access("lw20", 1'b0, 2'd2, 1'b0, 32'h20, '0, '0, 0);
    sb_push(32'hFFFF_8044, 1'b0);  access("lh20", 1'b0, 2'd1, 1'b1, 32'h20, '0, '0, 0);
    sb_push(32'h0000_8044, 1'b0);  access("lhu20", 1'b0, 2'd1, 1'b0, 32'h20, '0, '0, 0);
    sb_push(32'h0000_1122, 1'b0);  access("lhu22", 1'b0, 2'd1, 1'b0, 32'h22, '0, '0, 0);

    // Faults and decode boundaries.
    sb_push(32'hFFFF_FFFF, 1'b1);  access("lw02", 1'b0, 2'd2, 1'b0, 32'h2, '0, '0, 0);
    sb_push(32'hFFFF_FFFF, 1'b1);  access("sw5000", 1'b1, 2'd2, 1'b0, 32'h5000, 32'hDEAD_BEEF, '0, 0);
    chk("sw5000 pr_sel", 32'(sel_seen), 32'd0);
    chk("sw5000 stalls", 32'(n_stall), 32'd0);
    sb_push(32'hFFFF_FFFF, 1'b1);  access("lh11", 1'b0, 2'd1, 1'b0, 32'h11, '0, '0, 0);
    sb_push(32'hFFFF_FFFF, 1'b1);  access("size3", 1'b0, 2'd3, 1'b0, 32'h10, '0, '0, 0);
    sb_push(32'hFFFF_FFFF, 1'b1);  access("sw12", 1'b1, 2'd2, 1'b0, 32'h12, 32'h0, '0, 0);
    sb_push(32'h1234_5678, 1'b0);  access("lw10", 1'b0, 2'd2, 1'b0, 32'h10, '0, '0, 0);
    sb_push(32'h0, 1'b0);          access("lw2FFC", 1'b0, 2'd2, 1'b0, 32'h2FFC, '0, '0, 0);
    sb_push(32'hFFFF_FFFF, 1'b1);  access("lw3000", 1'b0, 2'd2, 1'b0, 32'h3000, '0, '0, 0);
    sb_push(32'hFFFF_FFFF, 1'b1);  access("lw7F20", 1'b0, 2'd2, 1'b0, 32'h7F20, '0, '0, 0);

    // Device read, ack in the third BUS cycle.
    sb_push(32'hCAFE_0001, 1'b0);  access("lw7F14", 1'b0, 2'd2, 1'b0, 32'h7F14, '0, 32'hCAFE_0001, 3);
    chk("lw7F14 pr_sel", 32'(sel_seen), 32'd2);
    chk("lw7F14 stalls", 32'(n_stall), 32'd4);
    chk("lw7F14 bus cycles", 32'(n_bus), 32'd3);
    chk("lw7F14 pr_addr", addr_seen, 32'h7F14);
    chk("lw7F14 pr_we", 32'(we_seen), 32'd0);
    @(negedge clk);
    chk("lw7F14 rvalid after", 32'(rvalid), 32'd0);
    @(posedge clk); #1;

    // Device half store and half load.
    sb_push(32'h0, 1'b0);          access("sh7F02", 1'b1, 2'd1, 1'b0, 32'h7F02, 32'h0000_ABCD, '0, 1);
    chk("sh7F02 pr_sel", 32'(sel_seen), 32'd1);
    chk("sh7F02 pr_be", 32'(be_seen), 32'hC);
    chk("sh7F02 pr_wdata", wd_seen, 32'hABCD_ABCD);
    chk("sh7F02 pr_addr", addr_seen, 32'h7F00);
    chk("sh7F02 pr_we", 32'(we_seen), 32'd1);
    chk("sh7F02 stalls", 32'(n_stall), 32'd2);
    sb_push(32'hFFFF_CAFE, 1'b0);  access("lh7F16", 1'b0, 2'd1, 1'b1, 32'h7F16, '0, 32'hCAFE_0001, 2);
    chk("lh7F16 stalls", 32'(n_stall), 32'd3);

    // Device store that is never acknowledged.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    addr = 32'h7F00; wdata = 32'h55; pr_ack = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    sb_push(32'hFFFF_FFFF, 1'b1);
    n_bus = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pr_sel != '0) n_bus++;
      if (rvalid) begin
        exp_t e;
        done = 1'b1;
        e = sb.pop_front();
        chk("tmo rdata", rdata, e.rdata);
        chk("tmo err", 32'(err), 32'(e.err));
      end
    end
    chk("tmo done", 32'(done), 32'd1);
    chk("tmo bus cycles", 32'(n_bus), 32'd15);
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
`else
    n_stall = 0;
    nrv     = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (rvalid) nrv++;
    end
    chk("noack stalls", 32'(n_stall), 32'd100);
    chk("noack rvalid", 32'(nrv), 32'd0);
`endif

    // Reset pulled mid-BUS.
    chk("pre-rst pr_sel", 32'(pr_sel), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst pr_sel", 32'(pr_sel), 32'd0);
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    sb_push(32'h0, 1'b0);          access("lw10 cleared", 1'b0, 2'd2, 1'b0, 32'h10, '0, '0, 0);
    sb_push(32'hCAFE_0001, 1'b0);  access("lw7F14 post", 1'b0, 2'd2, 1'b0, 32'h7F14, '0, 32'hCAFE_0001, 1);
    chk("post stalls", 32'(n_stall), 32'd2);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
